// File: rtl/ppm_tx_pkg.sv
// Shared types and constants for the PPM transmit controller.
package ppm_tx_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ENTRY_W = BYTE_W + 1;

    localparam logic [BYTE_W-1:0] PPM_PREAMBLE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PRE_WAIT,
        LOAD,
        WAIT,
        STALL,
        GAP
    } state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/ppm_byte_fifo.sv
// Byte buffer holding host bytes with their end-of-frame flag.
module ppm_byte_fifo
    import ppm_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  entry_t                         wr_entry,
    input  logic                           pop,
    output entry_t                         rd_entry_c,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_entry_c = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // full reads as set during reset so the host sees no space until released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/ppm_tx_ctrl.sv
// Frames buffered host bytes into a 2-bit symbol shifter, with inter-frame gap.
// Define PPM_TX_PREAMBLE_EN to send PPM_PREAMBLE ahead of every frame.
module ppm_tx_ctrl
    import ppm_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [BYTE_W-1:0] sh_data,
    output logic              sh_strobe,
    input  logic              sh_done,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GW = 8;

    state_t            state_q;
    state_t            state_next;
    logic [GW-1:0]     gap_cnt_q;
    logic              last_q;

    entry_t            wr_entry;
    entry_t            rd_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              have_data;

    logic              pop_c;
    logic              strobe_c;
    logic              frame_done_c;
    logic              underrun_c;
    logic [BYTE_W-1:0] data_c;

    assign wr_entry  = '{last: s_last, data: s_data};
    assign s_ready   = ~fifo_full;
    assign have_data = (fifo_count != CW'(0));

    ppm_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (s_valid),
        .wr_entry   (wr_entry),
        .pop        (pop_c),
        .rd_entry_c (rd_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
`ifdef PPM_TX_PREAMBLE_EN
                if (have_data) state_next = PRE;
`else
                if (have_data) state_next = LOAD;
`endif
            end
`ifdef PPM_TX_PREAMBLE_EN
            PRE:      state_next = PRE_WAIT;
            PRE_WAIT: if (sh_done) state_next = LOAD;
`endif
            LOAD:     state_next = WAIT;
            WAIT: begin
                if (sh_done) begin
                    if (last_q)         state_next = GAP;
                    else if (have_data) state_next = LOAD;
                    else                state_next = STALL;
                end
            end
            STALL:    if (have_data) state_next = LOAD;
            GAP:      if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // sh_data holds its value between strobes so the shifter sees a stable byte
    always_comb begin
        pop_c        = 1'b0;
        strobe_c     = 1'b0;
        frame_done_c = 1'b0;
        underrun_c   = 1'b0;
        data_c       = sh_data;
        case (state_q)
`ifdef PPM_TX_PREAMBLE_EN
            PRE: begin
                strobe_c = 1'b1;
                data_c   = PPM_PREAMBLE;
            end
`endif
            LOAD: begin
                pop_c    = 1'b1;
                strobe_c = 1'b1;
                data_c   = rd_entry.data;
            end
            WAIT: begin
                if (sh_done) begin
                    if (last_q)          frame_done_c = 1'b1;
                    else if (fifo_empty) underrun_c   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data    <= '0;
            sh_strobe  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            last_q     <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            sh_data    <= data_c;
            sh_strobe  <= strobe_c;
            busy       <= (state_next != IDLE);
            frame_done <= frame_done_c;
            underrun   <= underrun_c;
            if (state_q == LOAD) last_q <= rd_entry.last;
            if (state_q == GAP)  gap_cnt_q <= gap_cnt_q + GW'(1);
            else                 gap_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_ppm_tx_ctrl.sv
// Directed self-checking bench for ppm_tx_ctrl (either PPM_TX_PREAMBLE_EN setting).
module tb_ppm_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       sh_done = 1'b0;
    logic       s_ready;
    logic [7:0] sh_data;
    logic       sh_strobe;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int total = 0;
    int bad = 0;
    int strb_cnt = 0;
    int fd_cnt = 0;
    int ur_cnt = 0;
    int dbl_cnt = 0;
    int served = 0;
    logic prev_strobe = 1'b0;
    logic [7:0] got_q [$];

    always #5 clk = ~clk;

    ppm_tx_ctrl #(
        .FIFO_DEPTH (4),
        .GAP_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .sh_data    (sh_data),
        .sh_strobe  (sh_strobe),
        .sh_done    (sh_done),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (sh_strobe) begin
            strb_cnt++;
            got_q.push_back(sh_data);
        end
        if (sh_strobe && prev_strobe) dbl_cnt++;
        if (frame_done) fd_cnt++;
        if (underrun) ur_cnt++;
        prev_strobe = sh_strobe;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_loaded(input string tag);
        int n = 0;
        while (strb_cnt <= served && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(strb_cnt > served), 1);
    endtask

    // Expect the next strobe to carry exp, check it is held, then acknowledge it
    task automatic shift_one(input string tag, input logic [7:0] exp);
        wait_loaded({tag, "_seen"});
        if (strb_cnt > served) chk({tag, "_data"}, 32'(got_q[served]), 32'(exp));
        repeat (2) tick();
        chk({tag, "_hold"}, 32'(sh_data), 32'(exp));
        sh_done = 1'b1;
        tick();
        sh_done = 1'b0;
        served++;
    endtask

    task automatic pre_if();
`ifdef PPM_TX_PREAMBLE_EN
        shift_one("pre", 8'hA5);
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        int n;
        int s0;
        int fd0;
        int ur0;

        // reset values
        repeat (2) tick();
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_sh_data", 32'(sh_data), 0);
        chk("rst_sh_strobe", 32'(sh_strobe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_underrun", 32'(underrun), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_s_ready", 32'(s_ready), 1);

        // single-byte frame, latency, gap length, sh_done ignored in GAP
        fd0 = fd_cnt;
        ur0 = ur_cnt;
        push(8'h6C, 1'b1);
        tick();
        chk("t1_strobe_c1", 32'(sh_strobe), 0);
        tick();
        chk("t1_strobe_c2", 32'(sh_strobe), 1);
`ifdef PPM_TX_PREAMBLE_EN
        chk("t1_data_c2", 32'(sh_data), 32'h A5);
        shift_one("t1_pre", 8'hA5);
`else
        chk("t1_data_c2", 32'(sh_data), 32'h6C);
`endif
        shift_one("t1", 8'h6C);
        chk("t1_frame_done", 32'(frame_done), 1);
        chk("t1_busy", 32'(busy), 1);
        n = 1;
        while (busy && n < 50) begin
            sh_done = (n == 3);
            tick();
            if (busy) n++;
        end
        sh_done = 1'b0;
        chk("t1_gap_len", 32'(n), 8);
        chk("t1_fd_cnt", 32'(fd_cnt - fd0), 1);
        chk("t1_ur_cnt", 32'(ur_cnt - ur0), 0);

        // sh_done while idle
        sh_done = 1'b1;
        tick();
        sh_done = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_strobe", 32'(strb_cnt), 32'(served));
        chk("idle_fd", 32'(fd_cnt - fd0), 1);
        chk("idle_ur", 32'(ur_cnt - ur0), 0);

        // two-byte frame
        s0  = strb_cnt;
        fd0 = fd_cnt;
        push(8'h01, 1'b0);
        push(8'h02, 1'b1);
        pre_if();
        shift_one("f2a", 8'h01);
        shift_one("f2b", 8'h02);
        chk("f2_frame_done", 32'(frame_done), 1);
        wait_idle("f2_idle");
`ifdef PPM_TX_PREAMBLE_EN
        chk("f2_strobes", 32'(strb_cnt - s0), 3);
`else
        chk("f2_strobes", 32'(strb_cnt - s0), 2);
`endif
        chk("f2_fd_cnt", 32'(fd_cnt - fd0), 1);

        // buffer fills while the shifter holds off
        ur0 = ur_cnt;
        push(8'h10, 1'b0);
        pre_if();
        wait_loaded("full_b0_seen");
        push(8'h21, 1'b0);
        push(8'h22, 1'b0);
        push(8'h23, 1'b0);
        push(8'h24, 1'b0);
        chk("full_ready_low", 32'(s_ready), 0);
        s_data  = 8'h25;
        s_last  = 1'b1;
        s_valid = 1'b1;
        repeat (3) tick();
        chk("full_ready_held", 32'(s_ready), 0);
        shift_one("full_b0", 8'h10);
        chk("full_ready_prepop", 32'(s_ready), 0);
        tick();
        chk("full_ready_postpop", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        shift_one("full_b1", 8'h21);
        shift_one("full_b2", 8'h22);
        shift_one("full_b3", 8'h23);
        shift_one("full_b4", 8'h24);
        shift_one("full_b5", 8'h25);
        chk("full_frame_done", 32'(frame_done), 1);
        wait_idle("full_idle");
        chk("full_ur_cnt", 32'(ur_cnt - ur0), 0);

        // underrun, stall, resume without second preamble
        ur0 = ur_cnt;
        push(8'h30, 1'b0);
        pre_if();
        shift_one("ur_b0", 8'h30);
        chk("ur_pulse", 32'(underrun), 1);
        tick();
        chk("ur_pulse_end", 32'(underrun), 0);
        chk("ur_busy", 32'(busy), 1);
        s0 = strb_cnt;
        repeat (18) tick();
        chk("ur_stall_quiet", 32'(strb_cnt), 32'(s0));
        chk("ur_stall_busy", 32'(busy), 1);
        push(8'h31, 1'b1);
        shift_one("ur_b1", 8'h31);
        chk("ur_frame_done", 32'(frame_done), 1);
        chk("ur_cnt", 32'(ur_cnt - ur0), 1);
        wait_idle("ur_idle");

        // reset while waiting on the shifter with three bytes buffered
        push(8'h40, 1'b0);
        pre_if();
        wait_loaded("rw_b0_seen");
        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        push(8'h43, 1'b1);
        chk("rw_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rw_s_ready", 32'(s_ready), 0);
        chk("rw_sh_data", 32'(sh_data), 0);
        chk("rw_sh_strobe", 32'(sh_strobe), 0);
        chk("rw_busy", 32'(busy), 0);
        chk("rw_frame_done", 32'(frame_done), 0);
        chk("rw_underrun", 32'(underrun), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rw_rel_s_ready", 32'(s_ready), 1);
        served = strb_cnt;
        s0  = strb_cnt;
        fd0 = fd_cnt;
        ur0 = ur_cnt;
        repeat (10) tick();
        chk("rw_no_strobe", 32'(strb_cnt), 32'(s0));
        chk("rw_idle", 32'(busy), 0);
        chk("rw_no_fd", 32'(fd_cnt), 32'(fd0));
        chk("rw_no_ur", 32'(ur_cnt), 32'(ur0));

        chk("no_double_strobe", 32'(dbl_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppm_tx_ctrl.md
PPM_TX_CTRL -- requirements
Module: ppm_tx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, which sets the number of byte entries in the input buffer (power of two, 2..16).
REQ-002 SHALL have parameter GAP_CYCLES, default 8, which sets the idle clocks inserted after each frame (1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_data, input, 8 bits: host byte.
REQ-006 SHALL have port s_valid, input, 1 bit: host byte valid.
REQ-007 SHALL have port s_last, input, 1 bit: the current byte ends the frame.
REQ-008 SHALL have port s_ready, output, 1 bit: buffer can accept a byte.
REQ-009 SHALL have port sh_data, output, 8 bits: byte presented to the 2-bit symbol shifter.
REQ-010 SHALL have port sh_strobe, output, 1 bit: one-cycle load pulse to the shifter.
REQ-011 SHALL have port sh_done, input, 1 bit: one-cycle pulse from the shifter meaning its last symbol has been sent.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame's last byte completes.
REQ-014 SHALL have port underrun, output, 1 bit: one-cycle pulse when the shifter finishes mid-frame and the buffer is empty.

Function
REQ-015 SHALL accept a byte, with its s_last flag, on every rising edge where s_valid and s_ready are both high.
REQ-016 SHALL drive s_ready = not full; no write occurs when full, and a write attempt when full is ignored with no state change.
REQ-017 SHALL, on a simultaneous push and pop when not full, complete both, leaving the occupancy count unchanged.
REQ-018 SHALL implement FSM states IDLE, PRE, PRE_WAIT, LOAD, WAIT, STALL and GAP.
REQ-019 SHALL transition from IDLE to PRE when the buffer is non-empty (macro defined), or to LOAD otherwise.
REQ-020 SHALL, in PRE, drive sh_data = PPM_PREAMBLE and pulse sh_strobe, then go to PRE_WAIT; on sh_done, go to LOAD.
REQ-021 SHALL, in LOAD, pop one entry, register it onto sh_data, pulse sh_strobe, latch its last flag and go to WAIT.
REQ-022 SHALL hold sh_data stable from the strobe until the matching sh_done.
REQ-023 SHALL, in WAIT on sh_done: if the latched last flag is set, pulse frame_done and go to GAP; otherwise go to LOAD if non-empty, or pulse underrun and go to STALL.
REQ-024 SHALL, in STALL, go to LOAD when the buffer becomes non-empty; the frame resumes and the preamble is not repeated.
REQ-025 SHALL, in GAP, count GAP_CYCLES clocks, then go to IDLE; bytes may be accepted during GAP.
REQ-026 SHALL, with the macro undefined and IDLE with an empty buffer, raise sh_strobe exactly 2 clocks after the accepting edge.
REQ-027 SHALL ignore sh_done in any state other than PRE_WAIT and WAIT.
REQ-028 SHALL keep sh_strobe at no more than one pulse per byte, and never high in two consecutive cycles.

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE, an empty buffer, and outputs s_ready=0, sh_data=0, sh_strobe=0, busy=0, frame_done=0 and underrun=0.
REQ-030 SHALL discard all buffered bytes and any in-progress frame on reset mid-operation, with no pulses emitted after the reset releases.
REQ-031 SHALL drive s_ready=1 in the first cycle after reset release.

Configuration
REQ-032 SHALL, when PPM_TX_PREAMBLE_EN is defined, send the preamble byte before each frame's first byte via PRE and PRE_WAIT.
REQ-033 SHALL, when PPM_TX_PREAMBLE_EN is undefined, omit PRE and PRE_WAIT logic entirely so that IDLE goes directly to LOAD.

Structure
REQ-034 SHALL place the FSM state enumeration, PPM_PREAMBLE = 8'hA5 and the byte width constant in shared package ppm_tx_pkg.
REQ-035 SHALL implement the buffer as sub-module ppm_byte_fifo (9-bit entries: byte plus last flag, full/empty outputs, count).

Verification
REQ-036 SHALL cover: macro off, single byte 8'h6C with s_last -> sh_strobe 2 clocks later with sh_data=8'h6C; sh_done -> frame_done pulse, busy high for 8 GAP clocks.
REQ-037 SHALL cover: macro on, frame 8'h01, 8'h02 (last) -> sh_data sequence A5, 01, 02; exactly 3 strobes; 1 frame_done.
REQ-038 SHALL cover: push 5 bytes back-to-back with FIFO_DEPTH=4 while the shifter is stalled -> s_ready low after the 4th accept; the 5th byte is held by the host and accepted after the first pop.
REQ-039 SHALL cover: a 2-byte frame with the 2nd byte delayed 20 clocks -> underrun pulse after the 1st sh_done, STALL held, LOAD on arrival, no second preamble.
REQ-040 SHALL cover: rst_n low during WAIT with 3 bytes buffered -> all outputs 0 immediately; after release, s_ready=1, no strobe.
REQ-041 SHALL cover: sh_done injected in IDLE and GAP -> no state change and no pulses.
